load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- CPU-side initiator for the word-addressed data memory. Takes one RV32I load or store per request: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Drives the memory's mem_read, mem_write, word address and write data. Memory read data is combinational; writes commit on posedge clk.
- Sub-word stores are done as read-modify-write.
- Loads are extracted and sign- or zero-extended. Misaligned and illegal accesses return an error and never touch memory.

Parameters:
ADDR_WIDTH, 32, byte-address width of req_addr; mem_addr is ADDR_WIDTH-2 bits wide.

Ports:
clk  input  1  clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request.
req_is_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I funct3 (size/sign).
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  32  store data; low bits are used for SB/SH.
resp_valid  output  1  response available.
resp_ready  input  1  consumer accepts response.
resp_rdata  output  32  extended load data; 0 for stores and errors.
resp_error  output  1  misaligned address or illegal funct3.
mem_read  output  1  read strobe to data memory.
mem_write  output  1  write strobe to data memory.
mem_addr  output  ADDR_WIDTH-2  word index = latched addr >> 2.
mem_wdata  output  32  merged word to write.
mem_rdata  input  32  combinational read data from memory.

Behaviour:
- Reset: state IDLE. resp_valid=0, resp_rdata=0, resp_error=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, all latches cleared.
- mem_read and mem_write are additionally gated by !reset, so no memory write occurs in any cycle with reset high.
- Mid-operation reset abandons the access: no write, no response.
- States: IDLE, RD, WR, RESP. req_ready = (state==IDLE) && !reset.
- Accept: on an edge with req_valid && req_ready, latch is_store, funct3, addr, wdata.
- Decode on accept:
  - Illegal funct3: load funct3 in {3,6,7}; store funct3 >= 3.
  - Misaligned: funct3[1:0]==1 with addr[0]!=0, or funct3[1:0]==2 with addr[1:0]!=0.
  - Either condition sets error; next state RESP.
  - Otherwise: load -> RD; SW -> WR; SB/SH -> RD.
- RD: mem_read=1. On the edge, capture mem_rdata into rbuf. Load -> RESP; store -> WR.
- WR: mem_write=1, mem_wdata driven.
  - SW: mem_wdata = latched wdata.
  - SB: rbuf with byte lane addr[1:0] replaced by wdata[7:0].
  - SH: rbuf with halfword lane addr[1] replaced by wdata[15:0].
  - Next state RESP.
- RESP: resp_valid=1; resp_rdata and resp_error are stable.
  - Stays in RESP until resp_ready is sampled high, then goes to IDLE.
  - New requests are accepted only from IDLE: one outstanding access, no overlap.
- Load extraction from rbuf:
  - LB/LBU: byte addr[1:0], bits [8k+7:8k], sign- or zero-extended.
  - LH/LHU: halfword addr[1], sign- or zero-extended.
  - LW: whole word.
- mem_addr is driven from the latched word index at all times after the first accept. mem_wdata is 0 outside WR.
- Latency from accept edge to resp_valid (resp_ready held high), counted as cycles after the accept edge:
  - Load: 2.
  - SW: 2.
  - SB/SH: 3.
  - Error: 1.
- Next accept is possible 1 cycle after the response handshake.
- mem_read and mem_write are never both high.

Test Plan:
- Load extension: memory word[0x400]=0x80FF7F01. LB@0x1000 -> 0x00000001. LB@0x1003 -> 0xFFFFFF80. LBU@0x1003 -> 0x00000080. LH@0x1002 -> 0xFFFF80FF. LHU@0x1002 -> 0x000080FF. LW@0x1000 -> 0x80FF7F01. Each response arrives 2 cycles after accept.
- Sub-word store read-modify-write: word[0x407]=0x11223344. SB 0xAB@0x101D -> word=0x1122AB44, mem_read 1 cycle then mem_write 1 cycle. SH 0xBEEF@0x101E -> word=0xBEEFAB44. SW 0xDEADBEEF@0x101C -> 0xDEADBEEF with no mem_read cycle.
- Errors: LW@0x1001, SH@0x1003, load funct3=3, store funct3=4. Each gives resp_error=1, resp_rdata=0, response 1 cycle after accept, and mem_read=mem_write=0 throughout.
- Backpressure: hold resp_ready=0 for 5 cycles during a LW. resp_valid and resp_rdata stay stable; req_ready=0; a new req_valid is not accepted until 1 cycle after the handshake.
- Reset mid-access: assert reset while an SB is in WR. Word is unchanged (mem_write=0 that cycle); next cycle IDLE, req_ready=1, resp_valid=0.
- Back-to-back: SW 0x12345678@0x2000 then LW@0x2000 -> 0x12345678. Never more than one strobe active per cycle.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store initiator for a word-addressed data memory.
// Accepts one request at a time. Loads read one word and extract/extend the
// addressed byte or halfword. SW writes directly. SB/SH read the word, merge the
// new lane, then write it back. Misaligned or illegal requests respond with an
// error and never touch memory.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_is_store, req_funct3   operation select (RV32I funct3)
//   req_addr, req_wdata        byte address, store data
//   resp_valid/resp_ready      response handshake
//   resp_rdata, resp_error     extended load data (0 for stores/errors), error flag
//   mem_read, mem_write        memory strobes (never both high, low during reset)
//   mem_addr, mem_wdata        word index and merged write word
//   mem_rdata                  combinational memory read data
module load_store_unit #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            state_q,    state_d;
  logic                  is_store_q, is_store_d;
  logic [2:0]            funct3_q,   funct3_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [31:0]           wdata_q,    wdata_d;
  logic [31:0]           rbuf_q,     rbuf_d;
  logic [31:0]           rdata_q,    rdata_d;
  logic                  error_q,    error_d;

  logic                  accept;
  logic                  illegal;
  logic                  misaligned;
  logic [31:0]           merged;

  // Byte/halfword/word extraction with sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd4:    r = {24'd0, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd5:    r = {16'd0, h};
      3'd2:    r = word;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // Request decode, evaluated on the raw request inputs at accept time.
  always_comb begin
    if (req_is_store) begin
      illegal = (req_funct3 >= 3'd3);
    end else begin
      illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
    misaligned = ((req_funct3[1:0] == 2'd1) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'd2) && (req_addr[1:0] != 2'd0));
  end

  // Write word: new lane dropped into the buffered read word for SB/SH.
  always_comb begin
    merged = rbuf_q;
    case (funct3_q[1:0])
      2'd0:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      2'd2:    merged = wdata_q;
      default: merged = rbuf_q;
    endcase
  end

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;
  assign mem_read   = (state_q == S_RD) && !reset;
  assign mem_write  = (state_q == S_WR) && !reset;
  assign mem_addr   = addr_q[ADDR_WIDTH-1:2];
  assign mem_wdata  = (state_q == S_WR) ? merged : 32'd0;

  // Next-state and latch updates.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    rdata_d    = rdata_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          is_store_d = req_is_store;
          funct3_d   = req_funct3;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rdata_d    = 32'd0;
          error_d    = illegal || misaligned;
          if (illegal || misaligned) begin
            state_d = S_RESP;
          end else if (req_is_store && (req_funct3[1:0] == 2'd2)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        rbuf_d = mem_rdata;
        if (is_store_q) begin
          state_d = S_WR;
        end else begin
          rdata_d = load_extract(mem_rdata, funct3_q, addr_q[1:0]);
          state_d = S_RESP;
        end
      end
      S_WR: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      rdata_q    <= 32'd0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      rdata_q    <= rdata_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector bench for load_store_unit with a
// word-addressed memory model, plus hand sequences for backpressure and reset.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:4095];
  logic        pre_we;
  logic [11:0] pre_idx;
  logic [31:0] pre_data;

  int checks;
  int failures;
  int both_cnt;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          nrd;
    int          nwr;
    logic        chkw;
    logic [11:0] widx;
    logic [31:0] wexp;
  } vec_t;

  vec_t vt[$];

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:0]];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (mem_write) mem[mem_addr[11:0]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [11:0] idx, input logic [31:0] data);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er, output int nrd, output int nwr);
    int w;
    w = 0;
    lat = 0; rd = 32'd0; er = 1'b0; nrd = 0; nwr = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 32'(req_ready), 32'd1);
    end else begin
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 1; c <= 20; c++) begin
        if (mem_read) nrd++;
        if (mem_write) nwr++;
        if (resp_valid) begin
          lat = c; rd = resp_rdata; er = resp_error;
          break;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat, nrd, nwr, w;
    logic [31:0] rd;
    logic er;
    checks = 0; failures = 0; both_cnt = 0;
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    pre_we = 1'b0; pre_idx = 12'd0; pre_data = 32'd0;

    //     st    f3    addr        wdata        lat rdata        err  rd wr chkw  widx     wexp
    vt.push_back('{1'b0, 3'd0, 32'h1000, 32'h0,        2, 32'h00000001, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b0, 3'd0, 32'h1003, 32'h0,        2, 32'hFFFFFF80, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b0, 3'd4, 32'h1003, 32'h0,        2, 32'h00000080, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b0, 3'd0, 32'h1001, 32'h0,        2, 32'h0000007F, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b0, 3'd1, 32'h1002, 32'h0,        2, 32'hFFFF80FF, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b0, 3'd5, 32'h1002, 32'h0,        2, 32'h000080FF, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b0, 3'd1, 32'h1000, 32'h0,        2, 32'h00007F01, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b0, 3'd2, 32'h1000, 32'h0,        2, 32'h80FF7F01, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b1, 3'd0, 32'h101D, 32'h123456AB, 3, 32'h0,        1'b0, 1, 1, 1'b1, 12'h407, 32'h1122AB44});
    vt.push_back('{1'b1, 3'd1, 32'h101E, 32'hCAFEBEEF, 3, 32'h0,        1'b0, 1, 1, 1'b1, 12'h407, 32'hBEEFAB44});
    vt.push_back('{1'b1, 3'd2, 32'h101C, 32'hDEADBEEF, 2, 32'h0,        1'b0, 0, 1, 1'b1, 12'h407, 32'hDEADBEEF});
    vt.push_back('{1'b0, 3'd2, 32'h1001, 32'h0,        1, 32'h0,        1'b1, 0, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b1, 3'd1, 32'h101F, 32'h00005555, 1, 32'h0,        1'b1, 0, 0, 1'b1, 12'h407, 32'hDEADBEEF});
    vt.push_back('{1'b0, 3'd3, 32'h1000, 32'h0,        1, 32'h0,        1'b1, 0, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b0, 3'd6, 32'h1000, 32'h0,        1, 32'h0,        1'b1, 0, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b1, 3'd4, 32'h1000, 32'h11111111, 1, 32'h0,        1'b1, 0, 0, 1'b1, 12'h400, 32'h80FF7F01});
    vt.push_back('{1'b0, 3'd5, 32'h1001, 32'h0,        1, 32'h0,        1'b1, 0, 0, 1'b0, 12'h000, 32'h0});
    vt.push_back('{1'b1, 3'd2, 32'h2000, 32'h12345678, 2, 32'h0,        1'b0, 0, 1, 1'b1, 12'h800, 32'h12345678});
    vt.push_back('{1'b0, 3'd2, 32'h2000, 32'h0,        2, 32'h12345678, 1'b0, 1, 0, 1'b0, 12'h000, 32'h0});

    preload(12'h400, 32'h80FF7F01);
    preload(12'h407, 32'h11223344);
    preload(12'h800, 32'h00000000);

    // Reset state.
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Vector table.
    foreach (vt[i]) begin
      run_req(vt[i].st, vt[i].f3, vt[i].addr, vt[i].wdata, lat, rd, er, nrd, nwr);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      chk($sformatf("v%0d_error", i), 32'(er), 32'(vt[i].err));
      chk($sformatf("v%0d_read_cycles", i), 32'(nrd), 32'(vt[i].nrd));
      chk($sformatf("v%0d_write_cycles", i), 32'(nwr), 32'(vt[i].nwr));
      if (vt[i].chkw) chk($sformatf("v%0d_mem_word", i), mem[vt[i].widx], vt[i].wexp);
    end

    // Backpressure: LW held in RESP while a second request waits.
    resp_ready = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h1000; req_wdata = 32'd0;
    @(posedge clk); #1;
    req_addr = 32'h2000;
    w = 0;
    while (!resp_valid && w < 10) begin
      @(posedge clk); #1; w++;
    end
    chk("bp_resp_valid_seen", 32'(resp_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_resp_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("bp%0d_resp_rdata", k), resp_rdata, 32'h80FF7F01);
      chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_hs_resp_valid", 32'(resp_valid), 32'd0);
    chk("bp_after_hs_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_second_accepted", 32'(req_ready), 32'd0);
    chk("bp_second_mem_read", 32'(mem_read), 32'd1);
    w = 0;
    while (!resp_valid && w < 10) begin
      @(posedge clk); #1; w++;
    end
    chk("bp_second_rdata", resp_rdata, 32'h12345678);
    @(posedge clk); #1;

    // Reset while an SB is in its write cycle.
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h1000; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_rst_rd_cycle", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    chk("rmw_rst_wr_cycle", 32'(mem_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("rmw_rst_write_gated", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rmw_rst_req_ready", 32'(req_ready), 32'd1);
    chk("rmw_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rmw_rst_word", mem[12'h400], 32'h80FF7F01);
    @(posedge clk); #1;
    chk("rmw_rst_no_resp", 32'(resp_valid), 32'd0);

    chk("strobes_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
